// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin DDR command arbiter with high-priority port mask.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module ddr_port_arbiter #(
  parameter int               PORT_NUM       = 8,
  parameter int               ADDR_WIDTH     = 30,
  parameter int               NUM_WIDTH      = 16,
  parameter logic [7:0]       HI_PRI_MASK    = 8'b0000_0100,
  parameter int               TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_calib_complete,
  input  logic [PORT_NUM-1:0]            req_valid,
  input  logic [PORT_NUM-1:0]            req_wr,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORT_NUM*NUM_WIDTH-1:0]  req_num,
  output logic [PORT_NUM-1:0]            req_done,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic                           cmd_wr,
  output logic [ADDR_WIDTH-1:0]          cmd_addr,
  output logic [NUM_WIDTH-1:0]           cmd_num,
  output logic [2:0]                     cmd_id,
  input  logic                           ddr_done,
  output logic                           busy,
  output logic                           err_timeout,
  output logic [2:0]                     err_port,
  input  logic                           err_clr
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [2:0]            cmd_id_q, cmd_id_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [NUM_WIDTH-1:0]  cmd_num_q, cmd_num_d;
  logic [PORT_NUM-1:0]   req_done_q, req_done_d;
  logic                  busy_q, busy_d;
  logic [PORT_NUM-1:0]   elig, hi, pool;
  logic [2:0]            win;
  logic                  found;
  logic                  tmo;
  int                    idx;

  // a port whose done pulse is out this cycle must not be re-granted on the same edge
  always_comb begin
    elig = init_calib_complete ? (req_valid & ~req_done_q) : '0;
    hi   = elig & HI_PRI_MASK[PORT_NUM-1:0];
    pool = |hi ? hi : elig;
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = (int'(rr_ptr_q) + i) % PORT_NUM;
      if (!found && pool[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cmd_id_d   = cmd_id_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_num_d  = cmd_num_q;
    req_done_d = '0;
    case (state_q)
      S_IDLE: if (found) begin
        state_d    = S_ISSUE;
        cmd_id_d   = win;
        cmd_wr_d   = req_wr[win];
        cmd_addr_d = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_num_d  = req_num[int'(win)*NUM_WIDTH +: NUM_WIDTH];
      end
      S_ISSUE: if (cmd_ready) begin
        state_d  = S_BUSY;
        rr_ptr_d = (cmd_id_q == 3'(PORT_NUM-1)) ? 3'd0 : cmd_id_q + 3'd1;
      end
      S_BUSY: if (ddr_done || tmo) begin
        state_d              = S_IDLE;
        req_done_d[cmd_id_q] = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    cmd_valid_d = state_d == S_ISSUE;
    busy_d      = state_d != S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cmd_id_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_num_q   <= '0;
      req_done_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_id_q    <= cmd_id_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_num_q   <= cmd_num_d;
      req_done_q  <= req_done_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_num   = cmd_num_q;
  assign cmd_id    = cmd_id_q;
  assign req_done  = req_done_q;
  assign busy      = busy_q;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [2:0]  err_port_q, err_port_d;

  // counter sits at zero for BUSY entry; a coincident ddr_done beats expiry
  always_comb begin
    tmo        = state_q == S_BUSY && !ddr_done && cnt_q == 32'(TIMEOUT_CYCLES);
    cnt_d      = state_q == S_ISSUE ? 32'd0 : state_q == S_BUSY ? cnt_q + 32'd1 : cnt_q;
    err_d      = tmo ? 1'b1 : err_clr ? 1'b0 : err_q;
    err_port_d = tmo ? cmd_id_q : err_port_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_port_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_port_q <= err_port_d;
    end
  end

  assign err_timeout = err_q;
  assign err_port    = err_port_q;
`else
  logic unused_cfg;
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
  assign err_port    = '0;
  assign unused_cfg  = &{1'b0, err_clr, TIMEOUT_CYCLES[0]};
`endif
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: randomized bench for ddr_port_arbiter against a transaction-level model.
module tb_ddr_port_arbiter;
  localparam int P  = 8;
  localparam int AW = 30;
  localparam int NW = 16;
  localparam int T  = 20;
  localparam logic [P-1:0] HI = 8'b0000_0100;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, calib = 1'b0;
  logic [P-1:0] rv = '0, rw = '0;
  logic [P*AW-1:0] ra = '0;
  logic [P*NW-1:0] rn = '0;
  logic rdy = 1'b0, ddone = 1'b0, eclr = 1'b0;
  logic [P-1:0] req_done;
  logic cmd_valid, cmd_wr, busy, err_timeout;
  logic [AW-1:0] cmd_addr;
  logic [NW-1:0] cmd_num;
  logic [2:0] cmd_id, err_port;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.PORT_NUM(P), .ADDR_WIDTH(AW), .NUM_WIDTH(NW), .HI_PRI_MASK(HI), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(calib),
    .req_valid(rv), .req_wr(rw), .req_addr(ra), .req_num(rn), .req_done(req_done),
    .cmd_valid(cmd_valid), .cmd_ready(rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_num(cmd_num), .cmd_id(cmd_id), .ddr_done(ddone), .busy(busy),
    .err_timeout(err_timeout), .err_port(err_port), .err_clr(eclr)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] pa[P];
  logic [NW-1:0] pn[P];
  logic [P-1:0] en = '0;
  int req_pct = 0, rdy_pct = 0, dmin = 0, dmax = 0, spur_pct = 0, drop_pm = 0, clr_pct = 0, cal_flip = 0;
  bit keep_req = 0, hold = 0, fixed = 0, cal_en = 1;
  bit eng_act = 0;
  int eng_cnt = 0, cyc = 0, t_req = -1;
  bit prev_cv = 0;
  int grants[$];

  bit m_has, m_acc, m_wr, m_err;
  int m_id, m_rr, m_cnt, m_eport;
  logic [AW-1:0] m_addr;
  logic [NW-1:0] m_num;
  logic [P-1:0] m_done;

  // nearest requester at or after the pointer, measured as circular distance
  function automatic int pick(input logic [P-1:0] pool, input int rr);
    int best = -1, bd = P;
    for (int p = 0; p < P; p++)
      if (pool[p] && (p - rr + P) % P < bd) begin
        bd = (p - rr + P) % P;
        best = p;
      end
    return best;
  endfunction

  task automatic model_reset();
    m_has = 0; m_acc = 0; m_wr = 0; m_err = 0; m_id = 0; m_rr = 0; m_cnt = 0;
    m_eport = 0; m_addr = '0; m_num = '0; m_done = '0;
  endtask

  task automatic model_edge();
    logic [P-1:0] seen, elig, hp;
    bit tm;
    seen = m_done;
    m_done = '0;
    tm = 0;
    if (!m_has) begin
      elig = calib ? (rv & ~seen) : '0;
      hp = elig & HI;
      if (elig != '0) begin
        m_id = pick(hp != '0 ? hp : elig, m_rr);
        m_has = 1; m_acc = 0;
        m_wr = rw[m_id]; m_addr = pa[m_id]; m_num = pn[m_id];
      end
    end else if (!m_acc) begin
      if (rdy) begin m_acc = 1; m_rr = (m_id + 1) % P; m_cnt = 0; end
    end else if (ddone) begin
      m_done[m_id] = 1'b1; m_has = 0;
    end else if (TMO && m_cnt == T) tm = 1;
    else m_cnt++;
    if (tm) begin
      m_err = 1; m_eport = m_id; m_done[m_id] = 1'b1; m_has = 0;
    end else if (eclr) m_err = 0;
  endtask

  task automatic new_req(input int p);
    rv[p] = 1'b1;
    rw[p] = fixed ? 1'b1 : 1'($urandom);
    pa[p] = fixed ? '0 : AW'($urandom);
    pn[p] = fixed ? NW'(225) : NW'($urandom);
    if (p == 0 && t_req < 0) t_req = cyc;
  endtask

  task automatic pack();
    for (int p = 0; p < P; p++) begin
      ra[p*AW +: AW] = pa[p];
      rn[p*NW +: NW] = pn[p];
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check("cmd_valid", cmd_valid, m_has && !m_acc);
    check("busy", busy, m_has);
    check("req_done", req_done, m_done);
    check("cmd_id", cmd_id, m_id);
    check("cmd_wr", cmd_wr, m_wr);
    check("cmd_addr", cmd_addr, m_addr);
    check("cmd_num", cmd_num, m_num);
    check("err_timeout", err_timeout, m_err);
    check("err_port", err_port, m_eport);
    if (cmd_valid && !prev_cv) grants.push_back(int'(cmd_id));
    prev_cv = cmd_valid;
    if (cal_flip > 0 && $urandom % 100 < cal_flip) cal_en = !cal_en;
    calib = cal_en;
    for (int p = 0; p < P; p++) begin
      if (rv[p] && req_done[p]) begin
        if (en[p] && (keep_req || $urandom % 2 == 1)) new_req(p);
        else rv[p] = 1'b0;
      end else if (!rv[p]) begin
        if (en[p] && $urandom % 100 < req_pct) new_req(p);
      end else if ($urandom % 1000 < drop_pm) rv[p] = 1'b0;
    end
    ddone = 1'b0;
    if (eng_act) begin
      if (req_done != '0) eng_act = 0;
      else if (!hold) begin
        if (eng_cnt == 0) begin ddone = 1'b1; eng_act = 0; end
        else eng_cnt--;
      end
    end else if ($urandom % 100 < spur_pct) ddone = 1'b1;
    rdy = $urandom % 100 < rdy_pct;
    if (cmd_valid && rdy) begin eng_act = 1; eng_cnt = $urandom_range(dmax, dmin); end
    eclr = $urandom % 100 < clr_pct;
    pack();
    model_edge();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rv = '0; rw = '0; rdy = 0; ddone = 0; eclr = 0;
    for (int p = 0; p < P; p++) begin pa[p] = '0; pn[p] = '0; end
    pack();
    eng_act = 0; prev_cv = 0; t_req = -1;
    grants.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_done", req_done, 0);
    check("rst_cmd_fields", {cmd_wr, cmd_addr, cmd_num, cmd_id}, 0);
    check("rst_err", {err_timeout, err_port}, 0);
    calib = cal_en;
    rst_n = 1'b1;
    model_edge();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t_cv, t_dd, t_rd, t_b, n;
    int exp_b[6];
    exp_b = '{0, 1, 3, 0, 1, 3};
    // single port 0 write, ready tied high
    cal_en = 1; apply_reset();
    en = 8'b1; req_pct = 100; rdy_pct = 100; dmin = 9; dmax = 9; fixed = 1;
    t_cv = -1; t_dd = -1; t_rd = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (t_cv < 0 && cmd_valid) begin
        t_cv = cyc;
        check("A_id", cmd_id, 0);
        check("A_wr", cmd_wr, 1);
      end
      if (t_rd < 0 && t_dd >= 0 && req_done[0]) t_rd = cyc;
      if (t_dd < 0 && ddone) t_dd = cyc;
    end
    check("A_lat_cv", t_cv - t_req, 1);
    check("A_lat_done", t_rd - t_dd, 1);
    // round robin among 0,1,3
    fixed = 0; apply_reset();
    en = 8'b1011; keep_req = 1; dmin = 0; dmax = 3;
    n = 0;
    while (grants.size() < 6 && n < 300) begin step(); n++; end
    check("B_count", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("B_order", grants[i], exp_b[i]);
    // high priority port 2
    apply_reset();
    en = 8'b0111;
    n = 0;
    while (grants.size() < 6 && n < 300) begin step(); n++; end
    check("C_count", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i += 2) check("C_hi_first", grants[i], 2);
    // calibration gate
    cal_en = 0; apply_reset();
    en = 8'hFF; n = 0;
    for (int i = 0; i < 100; i++) begin step(); if (cmd_valid) n++; end
    check("D_no_grant", n, 0);
    cal_en = 1; step(); t_b = cyc;
    n = 0;
    while (!cmd_valid && n < 10) begin step(); n++; end
    check("D_lat", cyc - t_b, 1);
    // ready held low with spurious ddr_done
    apply_reset();
    en = 8'b1000_0000; keep_req = 0; rdy_pct = 0; spur_pct = 60;
    n = 0;
    while (!cmd_valid && n < 10) begin step(); n++; end
    check("E_cv", cmd_valid, 1);
    repeat (5) step();
    rdy_pct = 100; spur_pct = 0;
    repeat (30) step();
    // random traffic
    apply_reset();
    en = 8'hFF; req_pct = 30; rdy_pct = 60; dmin = 0; dmax = 8; spur_pct = 15;
    drop_pm = 5; clr_pct = 5; cal_flip = 2;
    repeat (3000) step();
    cal_flip = 0; cal_en = 1; drop_pm = 0; clr_pct = 0; spur_pct = 0;
    // withheld ddr_done, watchdog, async reset mid-burst
    apply_reset();
    en = 8'b10; req_pct = 100; rdy_pct = 100; hold = 1;
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    check("G_busy", busy, 1);
    t_b = cyc;
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (!req_done[1] && n < 40) begin step(); n++; end
    check("G_tmo_lat", cyc - t_b, 21);
    check("G_err", err_timeout, 1);
    check("G_eport", err_port, 1);
    en = '0; clr_pct = 100; step();
    clr_pct = 0; step();
    check("G_clr", err_timeout, 0);
    en = 8'b10; n = 0;
    while (!busy && n < 20) begin step(); n++; end
    check("G_busy2", busy, 1);
`else
    repeat (40) step();
    check("G_no_err", err_timeout, 0);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("H_cmd_valid", cmd_valid, 0);
    check("H_busy", busy, 0);
    check("H_req_done", req_done, 0);
    check("H_fields", {cmd_wr, cmd_addr, cmd_num, cmd_id}, 0);
    check("H_err", {err_timeout, err_port}, 0);
    hold = 0; apply_reset();
    en = 8'hFF; req_pct = 40; rdy_pct = 70;
    repeat (200) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
